// File: rtl/slant_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : slant_rd_arb
// Brief    : Two-requester (HDMI / transmit) read arbiter for the slant memory
//            with a T-path starvation guard and a fixed-latency return path.
// Revision : 1.0 - initial release
// ============================================================================
module slant_rd_arb #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 40,
    parameter int STARVE_MAX = 4
) (
    input  logic              Cclk,
    input  logic              rstn,
    input  logic              arb_en,
    input  logic              sof,
    input  logic              h_req,
    input  logic [ADDR_W-1:0] h_addr,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              t_req,
    input  logic [ADDR_W-1:0] t_addr,
    output logic              t_gnt,
    output logic              t_rvalid,
    output logic [DATA_W-1:0] t_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        h_miss_cnt,
    output logic              busy
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        HPRI   = 1'b0,
        TFORCE = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_starve;
    logic [c_CNT_W-1:0]  w_starve_nxt;
    logic                w_h_gnt;
    logic                w_t_gnt;
    logic                w_h_miss;

    logic                r_mem_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_tag1_src;
    logic                r_tag2_v;
    logic                r_tag2_src;
    logic                r_h_rvalid;
    logic                r_t_rvalid;
    logic [DATA_W-1:0]   r_h_rdata;
    logic [DATA_W-1:0]   r_t_rdata;
    logic [7:0]          r_h_miss;

    // TFORCE owns the cycle: H is locked out even when T has nothing to ask.
    always_comb begin
        w_h_gnt      = arb_en & h_req & (r_state == HPRI);
        w_t_gnt      = arb_en & t_req & ((r_state == TFORCE) | ~h_req);
        w_h_miss     = arb_en & h_req & ~w_h_gnt;
        w_starve_nxt = r_starve;
        if (sof || w_t_gnt) begin
            w_starve_nxt = '0;
        end else if (t_req && (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + c_CNT_W'(1);
        end
    end

    // The force is armed on the updated count so it lands in the very next cycle.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= HPRI;
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_nxt;
            if ((r_state == HPRI) && (w_starve_nxt == c_STARVE_MAX) && t_req) begin
                r_state <= TFORCE;
            end else begin
                r_state <= HPRI;
            end
        end
    end

    // mem_en doubles as the first tag-valid stage; tag2 lines up with mem_rdata.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_tag1_src <= 1'b0;
            r_tag2_v   <= 1'b0;
            r_tag2_src <= 1'b0;
            r_h_rvalid <= 1'b0;
            r_t_rvalid <= 1'b0;
            r_h_rdata  <= '0;
            r_t_rdata  <= '0;
            r_h_miss   <= '0;
        end else begin
            r_mem_en   <= w_h_gnt | w_t_gnt;
            r_tag1_src <= w_t_gnt;
            if (w_h_gnt || w_t_gnt) begin
                r_mem_addr <= w_t_gnt ? t_addr : h_addr;
            end
            r_tag2_v   <= r_mem_en;
            r_tag2_src <= r_tag1_src;
            r_h_rvalid <= r_tag2_v & ~r_tag2_src;
            r_t_rvalid <= r_tag2_v & r_tag2_src;
            if (r_tag2_v && !r_tag2_src) begin
                r_h_rdata <= mem_rdata;
            end
            if (r_tag2_v && r_tag2_src) begin
                r_t_rdata <= mem_rdata;
            end
            if (w_h_miss && (r_h_miss != 8'hFF)) begin
                r_h_miss <= r_h_miss + 8'd1;
            end
        end
    end

    assign h_gnt      = w_h_gnt;
    assign t_gnt      = w_t_gnt;
    assign mem_en     = r_mem_en;
    assign mem_addr   = r_mem_addr;
    assign h_rvalid   = r_h_rvalid;
    assign t_rvalid   = r_t_rvalid;
    assign h_rdata    = r_h_rdata;
    assign t_rdata    = r_t_rdata;
    assign h_miss_cnt = r_h_miss;
    assign busy       = r_mem_en | r_tag2_v;

endmodule
`default_nettype wire

// File: tb/tb_slant_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_slant_rd_arb
// Brief    : Self-checking bench for slant_rd_arb: directed table, corner
//            sequences and randomized traffic against a cycle-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slant_rd_arb;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 40;
    localparam int STARVE_MAX = 4;
    localparam int c_HIST     = 8192;

    logic              Cclk = 1'b0;
    logic              rstn = 1'b0;
    logic              arb_en = 1'b0;
    logic              sof = 1'b0;
    logic              h_req = 1'b0;
    logic              t_req = 1'b0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [ADDR_W-1:0] t_addr = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              h_gnt, t_gnt, h_rvalid, t_rvalid, mem_en, busy;
    logic [DATA_W-1:0] h_rdata, t_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        h_miss_cnt;

    slant_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .Cclk(Cclk), .rstn(rstn), .arb_en(arb_en), .sof(sof),
        .h_req(h_req), .h_addr(h_addr), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .t_req(t_req), .t_addr(t_addr), .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .h_miss_cnt(h_miss_cnt), .busy(busy)
    );

    always #5 Cclk = ~Cclk;

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 18'h2A5A5, 4'hC, a};
    endfunction

    // Memory answers one cycle after mem_en; junk otherwise so stray captures show.
    always @(posedge Cclk) begin
        if (mem_en) mem_rdata <= mem_fn(mem_addr);
        else        mem_rdata <= DATA_W'({$urandom(), $urandom()});
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference state: grant history per cycle plus starvation bookkeeping.
    bit                g_v   [c_HIST];
    bit                g_src [c_HIST];
    logic [ADDR_W-1:0] g_addr[c_HIST];
    int                cyc = 3;
    int                starve = 0;
    bit                force_t = 1'b0;
    int                miss = 0;
    logic [ADDR_W-1:0] exp_maddr = '0;
    logic [DATA_W-1:0] exp_hd = '0;
    logic [DATA_W-1:0] exp_td = '0;
    bit obs_hg, obs_tg, obs_men, obs_hv, obs_tv, obs_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_HIST; i++) g_v[i] = 1'b0;
        starve = 0; force_t = 1'b0; miss = 0;
        exp_maddr = '0; exp_hd = '0; exp_td = '0;
    endtask

    // Called at a falling edge; applies one cycle of inputs and checks every output.
    task automatic step(input bit en, input bit s, input bit hr, input bit tr,
                        input logic [ADDR_W-1:0] ha, input logic [ADDR_W-1:0] ta);
        bit eh, et, ehv, etv, emen, ebusy;
        arb_en = en; sof = s; h_req = hr; t_req = tr; h_addr = ha; t_addr = ta;
        #1;
        n_vec++;
        eh = 1'b0; et = 1'b0;
        if (en) begin
            if (force_t)  et = tr;
            else if (hr)  eh = 1'b1;
            else          et = tr;
        end
        emen  = g_v[cyc-1];
        ebusy = g_v[cyc-1] | g_v[cyc-2];
        ehv   = g_v[cyc-3] & ~g_src[cyc-3];
        etv   = g_v[cyc-3] &  g_src[cyc-3];
        if (ehv) exp_hd = mem_fn(g_addr[cyc-3]);
        if (etv) exp_td = mem_fn(g_addr[cyc-3]);
        chk("h_gnt",    64'(h_gnt),      64'(eh));
        chk("t_gnt",    64'(t_gnt),      64'(et));
        chk("mem_en",   64'(mem_en),     64'(emen));
        chk("mem_addr", 64'(mem_addr),   64'(exp_maddr));
        chk("h_rvalid", 64'(h_rvalid),   64'(ehv));
        chk("t_rvalid", 64'(t_rvalid),   64'(etv));
        chk("h_rdata",  64'(h_rdata),    64'(exp_hd));
        chk("t_rdata",  64'(t_rdata),    64'(exp_td));
        chk("h_miss",   64'(h_miss_cnt), 64'(miss));
        chk("busy",     64'(busy),       64'(ebusy));
        obs_hg = h_gnt; obs_tg = t_gnt; obs_men = mem_en;
        obs_hv = h_rvalid; obs_tv = t_rvalid; obs_busy = busy;
        g_v[cyc] = eh | et; g_src[cyc] = et; g_addr[cyc] = et ? ta : ha;
        if (eh | et) exp_maddr = et ? ta : ha;
        if (en && hr && !eh && miss < 255) miss++;
        if (s || et)                        starve = 0;
        else if (tr && starve < STARVE_MAX) starve++;
        force_t = !force_t && tr && (starve == STARVE_MAX);
        cyc++;
        @(negedge Cclk);
    endtask

    // Asserts reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rstn = 1'b0; arb_en = 1'b0; sof = 1'b0; h_req = 1'b0; t_req = 1'b0;
        #1;
        n_vec++;
        chk("rst_h_gnt",    64'(h_gnt),      64'd0);
        chk("rst_t_gnt",    64'(t_gnt),      64'd0);
        chk("rst_mem_en",   64'(mem_en),     64'd0);
        chk("rst_mem_addr", 64'(mem_addr),   64'd0);
        chk("rst_h_rvalid", 64'(h_rvalid),   64'd0);
        chk("rst_t_rvalid", 64'(t_rvalid),   64'd0);
        chk("rst_h_rdata",  64'(h_rdata),    64'd0);
        chk("rst_t_rdata",  64'(t_rdata),    64'd0);
        chk("rst_h_miss",   64'(h_miss_cnt), 64'd0);
        chk("rst_busy",     64'(busy),       64'd0);
        model_clear();
        @(negedge Cclk);
        @(negedge Cclk);
        rstn = 1'b1;
        cyc += 2;
    endtask

    typedef struct {
        bit en, s, hr, tr;
        logic [ADDR_W-1:0] ha, ta;
        bit xhg, xtg, xmen, xhv, xtv;
    } vec_t;

    function automatic vec_t mk(bit en, bit s, bit hr, bit tr, logic [ADDR_W-1:0] ha,
                                logic [ADDR_W-1:0] ta, bit xhg, bit xtg, bit xmen,
                                bit xhv, bit xtv);
        vec_t v;
        v.en = en; v.s = s; v.hr = hr; v.tr = tr; v.ha = ha; v.ta = ta;
        v.xhg = xhg; v.xtg = xtg; v.xmen = xmen; v.xhv = xhv; v.xtv = xtv;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        // Single H read, then eight alternating H/T grants draining back to back.
        tbl[0]  = mk(1,0,1,0,18'h00010,18'h0, 1,0,0,0,0);
        tbl[1]  = mk(1,0,0,0,18'h0,    18'h0, 0,0,1,0,0);
        tbl[2]  = mk(1,0,0,0,18'h0,    18'h0, 0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0,18'h0,    18'h0, 0,0,0,1,0);
        tbl[4]  = mk(1,0,0,0,18'h0,    18'h0, 0,0,0,0,0);
        tbl[5]  = mk(1,0,1,0,18'h00100,18'h0, 1,0,0,0,0);
        tbl[6]  = mk(1,0,0,1,18'h0,18'h00201, 0,1,1,0,0);
        tbl[7]  = mk(1,0,1,0,18'h00102,18'h0, 1,0,1,0,0);
        tbl[8]  = mk(1,0,0,1,18'h0,18'h00203, 0,1,1,1,0);
        tbl[9]  = mk(1,0,1,0,18'h00104,18'h0, 1,0,1,0,1);
        tbl[10] = mk(1,0,0,1,18'h0,18'h00205, 0,1,1,1,0);
        tbl[11] = mk(1,0,1,0,18'h00106,18'h0, 1,0,1,0,1);
        tbl[12] = mk(1,0,0,1,18'h0,18'h00207, 0,1,1,1,0);
        tbl[13] = mk(1,0,0,0,18'h0,    18'h0, 0,0,1,0,1);
        tbl[14] = mk(1,0,0,0,18'h0,    18'h0, 0,0,0,1,0);
        tbl[15] = mk(1,0,0,0,18'h0,    18'h0, 0,0,0,0,1);

        model_clear();
        @(negedge Cclk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].s, tbl[i].hr, tbl[i].tr, tbl[i].ha, tbl[i].ta);
            chk($sformatf("tbl%0d_h_gnt", i),    64'(obs_hg),  64'(tbl[i].xhg));
            chk($sformatf("tbl%0d_t_gnt", i),    64'(obs_tg),  64'(tbl[i].xtg));
            chk($sformatf("tbl%0d_mem_en", i),   64'(obs_men), 64'(tbl[i].xmen));
            chk($sformatf("tbl%0d_h_rvalid", i), 64'(obs_hv),  64'(tbl[i].xhv));
            chk($sformatf("tbl%0d_t_rvalid", i), 64'(obs_tv),  64'(tbl[i].xtv));
        end

        // Continuous contention: four H grants then one forced T grant.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 1, ADDR_W'(i), ADDR_W'(i + 64));
            chk($sformatf("cont%0d_t_gnt", i), 64'(obs_tg), 64'((i == 4) || (i == 9)));
            chk($sformatf("cont%0d_h_gnt", i), 64'(obs_hg), 64'((i != 4) && (i != 9)));
        end
        chk("cont_h_miss", 64'(h_miss_cnt), 64'd2);

        // sof at starve count 3 pushes the forced T grant out by four cycles.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, i == 3, 1, 1, ADDR_W'(i), ADDR_W'(i + 128));
            chk($sformatf("sof%0d_t_gnt", i), 64'(obs_tg), 64'(i == 8));
        end

        // arb_en dropped with two reads in flight.
        do_reset();
        step(1, 0, 1, 0, 18'h00AAA, 18'h0);
        step(1, 0, 0, 1, 18'h0, 18'h00BBB);
        for (int i = 2; i < 7; i++) begin
            step(0, 0, 1, 1, 18'h00CCC, 18'h00DDD);
            chk($sformatf("dis%0d_gnt", i),  64'(obs_hg | obs_tg), 64'd0);
            chk($sformatf("dis%0d_busy", i), 64'(obs_busy),        64'(i <= 3));
            chk($sformatf("dis%0d_hv", i),   64'(obs_hv),          64'(i == 3));
            chk($sformatf("dis%0d_tv", i),   64'(obs_tv),          64'(i == 4));
        end

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom()), ADDR_W'($urandom()));
        end

        // Long contention to drive h_miss_cnt into saturation.
        for (int i = 0; i < 1300; i++) begin
            step(1, 0, 1, 1, ADDR_W'($urandom()), ADDR_W'($urandom()));
        end
        chk("miss_sat", 64'(h_miss_cnt), 64'hFF);

        // Reset with two reads in flight: nothing may return afterwards.
        step(1, 0, 1, 0, 18'h01234, 18'h0);
        step(1, 0, 0, 1, 18'h0, 18'h04321);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 18'h0, 18'h0);
            chk($sformatf("post_rst%0d_rv", i), 64'(obs_hv | obs_tv), 64'd0);
        end
        chk("post_rst_miss", 64'(h_miss_cnt), 64'd0);

        // First grant right after release.
        step(1, 0, 0, 1, 18'h0, 18'h00777);
        chk("first_gnt", 64'(obs_tg), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 18'h0, 18'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slant_rd_arb.md
SLANT_RD_ARB -- requirements
Module: slant_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 18; width of the slant-memory read address.
REQ-002 Parameter DATA_W, default 40; read word width (4 banks x Y5 + C5).
REQ-003 Parameter STARVE_MAX, default 4; number of consecutive denied T cycles before a forced T grant.
REQ-004 Cclk  in  1  clock; all logic is rising-edge, single clock domain.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 arb_en  in  1  arbitration enable; when low, no grants are issued.
REQ-007 sof  in  1  start-of-frame pulse; clears the starvation counter.
REQ-008 h_req  in  1  HDMI-path read request.
REQ-009 h_addr  in  ADDR_W  HDMI read address, valid with h_req.
REQ-010 h_gnt  out  1  HDMI grant; combinational, same cycle as h_req.
REQ-011 h_rvalid  out  1  HDMI read-data valid strobe.
REQ-012 h_rdata  out  DATA_W  HDMI read data.
REQ-013 t_req, t_addr, t_gnt, t_rvalid, t_rdata  same widths/semantics as the h_* signals, for the transmit path.
REQ-014 mem_en  out  1  registered memory read enable.
REQ-015 mem_addr  out  ADDR_W  registered memory read address.
REQ-016 mem_rdata  in  DATA_W  memory data; valid exactly 1 cycle after mem_en.
REQ-017 h_miss_cnt  out  8  saturating count of cycles where h_req was denied.
REQ-018 busy  out  1  high while any read is in flight in the pipeline.

Function
REQ-019 At most one of h_gnt/t_gnt SHALL be high per cycle; a grant requires arb_en=1 and the matching req=1.
REQ-020 Normal priority: h_req wins over t_req.
REQ-021 starve_cnt SHALL increment (saturating at STARVE_MAX) on each cycle with t_req=1 and t_gnt=0, and clear on t_gnt or sof; sof wins over increment in the same cycle.
REQ-022 FSM states: HPRI, TFORCE. HPRI->TFORCE when starve_cnt==STARVE_MAX and t_req=1. In TFORCE, t_gnt=1 (if arb_en) regardless of h_req, then return to HPRI next cycle. TFORCE with t_req=0 returns to HPRI with no grant.
REQ-023 On a grant in cycle N: mem_en=1 and mem_addr=granted address in N+1; mem_rdata is sampled in N+2; the matching rvalid=1 with registered rdata in N+3 (fixed latency 3).
REQ-024 A 2-stage tag pipeline (valid, source) SHALL route each return to exactly one requester; back-to-back grants every cycle SHALL be supported with no bubbles.
REQ-025 mem_en=0 in cycles following no grant; mem_addr holds its last value.
REQ-026 h_miss_cnt SHALL increment on h_req=1 and h_gnt=0 with arb_en=1, saturate at 8'hFF, and clear only on reset.
REQ-027 arb_en falling SHALL stop new grants but let in-flight reads complete and return.
REQ-028 busy = OR of mem_en and the pipeline tag valids.
REQ-029 rdata for a requester SHALL hold its last value when its rvalid=0.

Reset
REQ-030 On rstn low, asynchronously: state HPRI, starve_cnt=0, mem_en=0, mem_addr=0, tag pipeline cleared, h_rvalid=t_rvalid=0, h_rdata=t_rdata=0, h_miss_cnt=0, busy=0.
REQ-031 Reset asserted mid-transfer SHALL drop in-flight reads; no rvalid SHALL be issued for them after release.
REQ-032 First grant is possible in the first cycle after rstn deasserts.

Verification
REQ-033 Single H read: arb_en=1, h_req=1 with h_addr=0x00010 for one cycle -> h_gnt same cycle, mem_en/mem_addr=0x00010 at +1, h_rvalid with h_rdata=mem_rdata at +3, t_rvalid stays 0.
REQ-034 Contention: h_req and t_req held high continuously, STARVE_MAX=4 -> pattern of 4 H grants then 1 T grant repeating; h_miss_cnt increments once per T grant.
REQ-035 sof clears starvation: t_req held, h_req held, sof pulsed when starve_cnt=3 -> starve_cnt=0, the next T grant is delayed by 4 further cycles.
REQ-036 Back-to-back mixed: alternating H/T grants for 8 cycles -> 8 rvalid strobes on consecutive cycles, each routed to the correct requester with the correct data.
REQ-037 arb_en dropped with 2 reads in flight -> no new grants, both rvalids delivered, busy falls 1 cycle after the last rvalid's data sample.
REQ-038 rstn pulsed low with 2 reads in flight -> all outputs at reset values immediately; no rvalid after release; h_miss_cnt=0.
